// File: rtl/qspi_phase_sequencer.sv
// QSPI basic-mode transaction sequencer: drives CS/SCLK and per-phase shift strobes (CMD/ADDR/CFG/DUMMY/DATA/CS_HOLD).
// Latency: first phase active one sys_clk after the accepted request; done pulses on the last CS_HOLD cycle.
// Backpressure: TX empty at a due pop or RX full at a due push freezes the SCLK counter with SCLK at idle level.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   qspi_basic_mode_req/en/wr start pulse, enable, direction (1 = write)
//   qspi_prescaler..data_mode transaction configuration, snapshotted on acceptance
//   tx_fifo_empty, rx_fifo_full FIFO status
//   qspi_busy, qspi_done      status back to the register block
//   qspi_cs_n, qspi_sclk      serial bus control
//   phase, lanes              current phase and its lane select (to the shifter)
//   shift_strobe              shifter advance, last sys_clk of each shifting SCLK period
//   tx_fifo_read, rx_fifo_write FIFO pop / push pulses
module qspi_phase_sequencer (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       qspi_basic_mode_req,
  input  logic       qspi_en,
  input  logic       qspi_wr,
  input  logic [1:0] qspi_prescaler,
  input  logic       qspi_sclk_mode,
  input  logic [2:0] qspi_cs_ht,
  input  logic       qspi_cmd_length,
  input  logic [2:0] qspi_addr_length,
  input  logic [3:0] qspi_cfg_length,
  input  logic [4:0] qspi_dummy_length,
  input  logic [8:0] qspi_data_length,
  input  logic [1:0] qspi_cmd_mode,
  input  logic [1:0] qspi_addr_mode,
  input  logic [1:0] qspi_data_mode,
  input  logic       tx_fifo_empty,
  input  logic       rx_fifo_full,
  output logic       qspi_busy,
  output logic       qspi_done,
  output logic       qspi_cs_n,
  output logic       qspi_sclk,
  output logic [2:0] phase,
  output logic [1:0] lanes,
  output logic       shift_strobe,
  output logic       tx_fifo_read,
  output logic       rx_fifo_write
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_CMD   = 3'd1;
  localparam logic [2:0] PH_ADDR  = 3'd2;
  localparam logic [2:0] PH_CFG   = 3'd3;
  localparam logic [2:0] PH_DUMMY = 3'd4;
  localparam logic [2:0] PH_DATA  = 3'd5;
  localparam logic [2:0] PH_HOLD  = 3'd6;

  typedef struct packed {
    logic       wr;
    logic [1:0] prescaler;
    logic       sclk_mode;
    logic [2:0] cs_ht;
    logic       cmd_len;
    logic [2:0] addr_len;
    logic [3:0] cfg_len;
    logic [4:0] dummy_len;
    logic [8:0] data_len;
    logic [1:0] cmd_mode;
    logic [1:0] addr_mode;
    logic [1:0] data_mode;
  } cfg_t;

  // log2 of the lane count: 00 -> 1 lane, 01 -> 2 lanes, 1x -> 4 lanes
  function automatic logic [1:0] lane_shift(input logic [1:0] mode);
    if (mode == 2'b00)      return 2'd0;
    else if (mode == 2'b01) return 2'd1;
    else                    return 2'd2;
  endfunction

  // Length of a phase in SCLK periods. 511 data bytes on one lane is
  // 4088 periods, so 12 bits hold every case without wrapping.
  function automatic logic [11:0] phase_len(input logic [2:0] ph, input cfg_t c);
    logic [11:0] bits;
    logic [11:0] rnd;
    logic [1:0]  sh;
    bits = '0;
    sh   = '0;
    case (ph)
      PH_CMD: begin
        bits = c.cmd_len ? 12'd8 : 12'd0;
        sh   = lane_shift(c.cmd_mode);
      end
      PH_ADDR: begin
        bits = (c.addr_len > 3'd4) ? 12'd32 : {6'd0, c.addr_len, 3'b000};
        sh   = lane_shift(c.addr_mode);
      end
      PH_CFG: begin
        bits = (c.cfg_len > 4'd8) ? 12'd8 : {8'd0, c.cfg_len};
        sh   = lane_shift(c.data_mode);
      end
      PH_DATA: begin
        bits = {c.data_len, 3'b000};
        sh   = lane_shift(c.data_mode);
      end
      default: ;
    endcase
    rnd = (12'd1 << sh) - 12'd1;
    if (ph == PH_DUMMY)     return {7'd0, c.dummy_len};
    else if (ph == PH_HOLD) return {8'd0, {1'b0, c.cs_ht} + 4'd1};
    else                    return (bits + rnd) >> sh;
  endfunction

  // First non-empty phase after ph; CS_HOLD when everything left is empty.
  function automatic logic [2:0] next_phase(input logic [2:0] ph, input cfg_t c);
    logic [2:0] nxt;
    nxt = PH_HOLD;
    for (int p = 5; p >= 1; p--) begin
      if (3'(p) > ph && phase_len(3'(p), c) != 12'd0) nxt = 3'(p);
    end
    return nxt;
  endfunction

  cfg_t        cfg_in;
  cfg_t        cfg_q;
  logic [2:0]  div_cnt;
  logic [11:0] per_cnt;
  logic        push_pend;

  logic        period_end, per_last, in_data, shifting, toggling;
  logic        pop_due, stall, advance, push_set;
  logic [1:0]  sh_data;
  logic [4:0]  word_bits, word_bits_next;

  always_comb begin
    cfg_in.wr        = qspi_wr;
    cfg_in.prescaler = qspi_prescaler;
    cfg_in.sclk_mode = qspi_sclk_mode;
    cfg_in.cs_ht     = qspi_cs_ht;
    cfg_in.cmd_len   = qspi_cmd_length;
    cfg_in.addr_len  = qspi_addr_length;
    cfg_in.cfg_len   = qspi_cfg_length;
    cfg_in.dummy_len = qspi_dummy_length;
    cfg_in.data_len  = qspi_data_length;
    cfg_in.cmd_mode  = qspi_cmd_mode;
    cfg_in.addr_mode = qspi_addr_mode;
    cfg_in.data_mode = qspi_data_mode;
  end

  always_comb begin
    period_end = (div_cnt == {cfg_q.prescaler, 1'b1});
    per_last   = (per_cnt == phase_len(phase, cfg_q) - 12'd1);
    in_data    = (phase == PH_DATA);
    shifting   = (phase == PH_CMD) || (phase == PH_ADDR) || (phase == PH_CFG) || in_data;
    toggling   = shifting || (phase == PH_DUMMY);
    sh_data    = lane_shift(cfg_q.data_mode);
    // Only the low 5 bits of the data bit count matter for word (32-bit) boundaries.
    word_bits      = 5'(per_cnt[4:0] << sh_data);
    word_bits_next = word_bits + 5'(5'd1 << sh_data);

    pop_due   = in_data && cfg_q.wr && (div_cnt == 3'd0) && (word_bits == 5'd0);
    stall     = (pop_due && tx_fifo_empty) || (push_pend && rx_fifo_full);
    advance   = (phase != PH_IDLE) && !stall;

    shift_strobe  = shifting && advance && period_end;
    tx_fifo_read  = pop_due && !tx_fifo_empty;
    rx_fifo_write = push_pend && !rx_fifo_full;
    // Push is requested by the strobe that completes a word or the final byte.
    push_set = in_data && !cfg_q.wr && shift_strobe && ((word_bits_next == 5'd0) || per_last);

    qspi_busy = (phase != PH_IDLE);
    qspi_cs_n = (phase == PH_IDLE) || (phase == PH_HOLD);
    qspi_done = (phase == PH_HOLD) && advance && period_end && per_last;

    if (phase == PH_IDLE) qspi_sclk = qspi_sclk_mode;
    else qspi_sclk = cfg_q.sclk_mode ^ (toggling && advance && (div_cnt > {1'b0, cfg_q.prescaler}));

    case (phase)
      PH_CMD:           lanes = cfg_q.cmd_mode;
      PH_ADDR:          lanes = cfg_q.addr_mode;
      PH_CFG, PH_DATA:  lanes = cfg_q.data_mode;
      default:          lanes = 2'b00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase     <= PH_IDLE;
      div_cnt   <= '0;
      per_cnt   <= '0;
      push_pend <= 1'b0;
      cfg_q     <= '0;
    end else begin
      if (phase == PH_IDLE) begin
        if (qspi_basic_mode_req && qspi_en) begin
          cfg_q   <= cfg_in;
          phase   <= next_phase(PH_IDLE, cfg_in);
          div_cnt <= '0;
          per_cnt <= '0;
        end
      end else if (advance) begin
        if (period_end) begin
          div_cnt <= '0;
          if (per_last) begin
            per_cnt <= '0;
            phase   <= (phase == PH_HOLD) ? PH_IDLE : next_phase(phase, cfg_q);
          end else begin
            per_cnt <= per_cnt + 12'd1;
          end
        end else begin
          div_cnt <= div_cnt + 3'd1;
        end
      end
      if (push_set)           push_pend <= 1'b1;
      else if (rx_fifo_write) push_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
module tb_qspi_phase_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req = 1'b0, en = 1'b1, wr = 1'b0;
  logic [1:0] pre = '0;
  logic       smode = 1'b1;
  logic [2:0] csht = '0;
  logic       cmdl = 1'b0;
  logic [2:0] addrl = '0;
  logic [3:0] cfgl = '0;
  logic [4:0] dumml = '0;
  logic [8:0] datal = '0;
  logic [1:0] cm = '0, am = '0, dm = '0;
  logic       tx_empty = 1'b0, rx_full = 1'b0;

  logic       qspi_busy, qspi_done, qspi_cs_n, qspi_sclk;
  logic [2:0] phase;
  logic [1:0] lanes;
  logic       shift_strobe, tx_fifo_read, rx_fifo_write;

  qspi_phase_sequencer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .qspi_basic_mode_req(req), .qspi_en(en), .qspi_wr(wr),
    .qspi_prescaler(pre), .qspi_sclk_mode(smode), .qspi_cs_ht(csht),
    .qspi_cmd_length(cmdl), .qspi_addr_length(addrl), .qspi_cfg_length(cfgl),
    .qspi_dummy_length(dumml), .qspi_data_length(datal),
    .qspi_cmd_mode(cm), .qspi_addr_mode(am), .qspi_data_mode(dm),
    .tx_fifo_empty(tx_empty), .rx_fifo_full(rx_full),
    .qspi_busy(qspi_busy), .qspi_done(qspi_done), .qspi_cs_n(qspi_cs_n),
    .qspi_sclk(qspi_sclk), .phase(phase), .lanes(lanes),
    .shift_strobe(shift_strobe), .tx_fifo_read(tx_fifo_read), .rx_fifo_write(rx_fifo_write)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int cs_low;
    int strobes;
    int sclk_per;
    int hold;
    int pops;
    int pushes;
    int done;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int lane_cnt(input logic [1:0] m);
    if (m == 2'b00) return 1;
    if (m == 2'b01) return 2;
    return 4;
  endfunction

  // Monitor: accumulates per-transaction activity, scores it when busy falls.
  int   a_cs_low = 0, a_hold = 0, a_strobes = 0, a_sclk = 0, a_pops = 0, a_pushes = 0, a_done = 0;
  int   completions = 0, idle_pulses = 0, bad_fifo = 0;
  logic prev_busy = 1'b0, prev_sclk = 1'b1, cur_mode = 1'b1;

  always @(negedge sys_clk) begin
    if (qspi_busy) begin
      if (!qspi_cs_n) a_cs_low++; else a_hold++;
      if (shift_strobe)  a_strobes++;
      if (tx_fifo_read)  a_pops++;
      if (rx_fifo_write) a_pushes++;
      if (qspi_done)     a_done++;
      if (prev_sclk == cur_mode && qspi_sclk != cur_mode) a_sclk++;
      if ((rx_fifo_write && rx_full) || (tx_fifo_read && tx_empty)) bad_fifo++;
    end else if (shift_strobe || tx_fifo_read || rx_fifo_write || qspi_done) begin
      idle_pulses++;
    end
    if (prev_busy && !qspi_busy) begin
      check_eq("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        check_eq("done_pulses", a_done, e_mon.done);
        if (e_mon.cs_low >= 0) begin
          check_eq("cs_low_cycles", a_cs_low, e_mon.cs_low);
          check_eq("cs_hold_cycles", a_hold, e_mon.hold);
          check_eq("shift_strobes", a_strobes, e_mon.strobes);
          check_eq("sclk_periods", a_sclk, e_mon.sclk_per);
          check_eq("tx_pops", a_pops, e_mon.pops);
          check_eq("rx_pushes", a_pushes, e_mon.pushes);
        end
      end
      a_cs_low = 0; a_hold = 0; a_strobes = 0; a_sclk = 0;
      a_pops = 0; a_pushes = 0; a_done = 0;
      completions++;
    end
    prev_busy = qspi_busy;
    prev_sclk = qspi_sclk;
  end

  // Drives a request (called just after a rising edge) and pushes its expectation.
  task automatic start_txn(input logic w, input logic [1:0] p, input logic sm, input logic [2:0] ch,
                           input logic c, input logic [2:0] a, input logic [3:0] g, input logic [4:0] d,
                           input logic [8:0] n, input logic [1:0] mc, input logic [1:0] ma,
                           input logic [1:0] md, input int stall, input bit abort);
    exp_t e;
    int pc, pa, pg, pd, pn, per, fp, fl;
    pc  = c ? ceil_div(8, lane_cnt(mc)) : 0;
    pa  = ceil_div(8 * ((int'(a) > 4) ? 4 : int'(a)), lane_cnt(ma));
    pg  = ceil_div((int'(g) > 8) ? 8 : int'(g), lane_cnt(md));
    pd  = int'(d);
    pn  = ceil_div(8 * int'(n), lane_cnt(md));
    per = 2 * (int'(p) + 1);
    e.cs_low   = (pc + pa + pg + pd + pn) * per + stall;
    e.strobes  = pc + pa + pg + pn;
    e.sclk_per = pc + pa + pg + pd + pn;
    e.hold     = (int'(ch) + 1) * per;
    e.pops     = w ? ceil_div(int'(n), 4) : 0;
    e.pushes   = w ? 0 : ceil_div(int'(n), 4);
    e.done     = 1;
    if (abort) begin
      e.cs_low = -1; e.strobes = -1; e.sclk_per = -1; e.hold = -1;
      e.pops = -1; e.pushes = -1; e.done = 0;
    end
    fp = (pc > 0) ? 1 : (pa > 0) ? 2 : (pg > 0) ? 3 : (pd > 0) ? 4 : (pn > 0) ? 5 : 6;
    fl = (fp == 1) ? int'(mc) : (fp == 2) ? int'(ma) : (fp == 3 || fp == 5) ? int'(md) : 0;
    wr = w; pre = p; smode = sm; csht = ch; cmdl = c; addrl = a; cfgl = g;
    dumml = d; datal = n; cm = mc; am = ma; dm = md; en = 1'b1;
    cur_mode = sm;
    req = 1'b1;
    sb.push_back(e);
    @(posedge sys_clk); #1;
    req = 1'b0;
    check_eq("start_busy", qspi_busy, 1);
    check_eq("start_phase", phase, fp);
    check_eq("start_lanes", lanes, fl);
    check_eq("start_cs_n", qspi_cs_n, (fp == 6) ? 1 : 0);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 6000 && completions < target; i++) @(posedge sys_clk);
    #1;
    check_eq("txn_complete", completions, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_busy", qspi_busy, 0);
    check_eq("rst_done", qspi_done, 0);
    check_eq("rst_cs_n", qspi_cs_n, 1);
    check_eq("rst_sclk_idle", qspi_sclk, smode);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_lanes", lanes, 0);
    check_eq("rst_strobes", {shift_strobe, tx_fifo_read, rx_fifo_write}, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // command-only single-lane write
    start_txn(1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0, 5'd0, 9'd0, 2'd0, 2'd0, 2'd0, 0, 1'b0);
    wait_done(1);

    // quad read: 3 addr bytes, 8 dummy, 8 data bytes, idle-high SCLK
    start_txn(1'b0, 2'd1, 1'b1, 3'd1, 1'b0, 3'd3, 4'd0, 5'd8, 9'd8, 2'd2, 2'd2, 2'd2, 0, 1'b0);
    wait_done(2);

    // write of 5 bytes, TX empty over the second word boundary for 20 cycles
    start_txn(1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 5'd0, 9'd5, 2'd0, 2'd0, 2'd0, 20, 1'b0);
    @(posedge sys_clk); #1;
    tx_empty = 1'b1;
    repeat (83) @(posedge sys_clk);
    #1;
    tx_empty = 1'b0;
    wait_done(3);

    // read of 8 bytes, RX full over the first word push for 10 cycles
    start_txn(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 5'd0, 9'd8, 2'd0, 2'd0, 2'd0, 10, 1'b0);
    @(posedge sys_clk); #1;
    rx_full = 1'b1;
    repeat (73) @(posedge sys_clk);
    #1;
    rx_full = 1'b0;
    wait_done(4);

    // request with enable low is dropped
    en = 1'b0; cmdl = 1'b1; req = 1'b1;
    @(posedge sys_clk); #1;
    req = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("dropped_busy", qspi_busy, 0);
    check_eq("dropped_cs_n", qspi_cs_n, 1);

    // second request while busy is dropped and config changes do not leak in
    start_txn(1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0, 5'd0, 9'd4, 2'd1, 2'd0, 2'd1, 0, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    req = 1'b1; datal = 9'd100; wr = 1'b0; cmdl = 1'b0;
    @(posedge sys_clk); #1;
    req = 1'b0;
    check_eq("busy_req_busy", qspi_busy, 1);
    check_eq("busy_req_cs_n", qspi_cs_n, 0);
    wait_done(5);

    // clamped addr (7 -> 4 bytes, dual) and cfg (15 -> 8 bits, quad), dummy 3
    start_txn(1'b1, 2'd0, 1'b0, 3'd2, 1'b0, 3'd7, 4'd15, 5'd3, 9'd0, 2'd0, 2'd1, 2'd2, 0, 1'b0);
    wait_done(6);

    // odd cfg bit count rounds up on dual lanes, prescaler 2
    start_txn(1'b0, 2'd2, 1'b0, 3'd0, 1'b1, 3'd0, 4'd5, 5'd0, 9'd0, 2'd2, 2'd0, 2'd1, 0, 1'b0);
    wait_done(7);

    // all phases empty: straight to CS_HOLD, maximal hold time
    start_txn(1'b1, 2'd3, 1'b0, 3'd7, 1'b0, 3'd0, 4'd0, 5'd0, 9'd0, 2'd0, 2'd0, 2'd0, 0, 1'b0);
    wait_done(8);

    // 511-byte quad read: 1022 periods, 128 pushes with a partial last word
    start_txn(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 5'd0, 9'd511, 2'd0, 2'd0, 2'd2, 0, 1'b0);
    wait_done(9);

    // reset in the middle of DATA
    start_txn(1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 5'd0, 9'd8, 2'd0, 2'd0, 2'd0, 0, 1'b1);
    repeat (29) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check_eq("midrst_busy", qspi_busy, 0);
    check_eq("midrst_cs_n", qspi_cs_n, 1);
    check_eq("midrst_sclk", qspi_sclk, smode);
    check_eq("midrst_done", qspi_done, 0);
    check_eq("midrst_phase", phase, 0);
    check_eq("midrst_fifo", {tx_fifo_read, rx_fifo_write}, 0);
    sys_rst = 1'b0;
    wait_done(10);

    // normal transaction after the reset
    start_txn(1'b0, 2'd0, 1'b1, 3'd0, 1'b1, 3'd1, 4'd0, 5'd0, 9'd4, 2'd0, 2'd0, 2'd0, 0, 1'b0);
    wait_done(11);

    check_eq("sb_empty", sb.size(), 0);
    check_eq("idle_pulses", idle_pulses, 0);
    check_eq("fifo_protocol", bad_fifo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
